// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC receive controller.
package hdlc_pkg;

  localparam logic [7:0] FLAG_BYTE = 8'h7E;

  // A flag carries a run of six ones; five ones followed by a zero is a stuffed zero.
  localparam logic [2:0] FLAG_RUN  = 3'($countones(FLAG_BYTE));
  localparam logic [2:0] STUFF_RUN = FLAG_RUN - 3'd1;

  typedef enum logic [2:0] {
    DATA0,
    DATA1,
    STUFF,
    SIX,
    FLAG,
    ABORT
  } bit_class_e;

  typedef enum logic [1:0] {
    HUNT,
    OPEN,
    DATA
  } rx_state_e;

  typedef struct packed {
    logic       abort;
    logic       sof;
    logic       eof;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/hdlc_rx_ctrl_if.sv
// Bit-strobe input side and valid/ready byte output side of the receiver.
interface hdlc_rx_ctrl_if;
  logic       en;
  logic       din;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eof;
  logic       out_abort;
  logic       ovf;

  modport master (
    output en, din, out_ready,
    input  out_valid, out_data, out_sof, out_eof, out_abort, ovf
  );

  modport slave (
    input  en, din, out_ready,
    output out_valid, out_data, out_sof, out_eof, out_abort, ovf
  );
endinterface

// File: rtl/hdlc_bit_class.sv
// Tracks the run of consecutive ones on the line and classifies each strobed bit.
module hdlc_bit_class
  import hdlc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_din,
  output bit_class_e o_class
);

  logic [2:0] r_ones;
  logic [2:0] w_ones_nxt;

  // Classify the current bit against the ones run seen so far.
  always_comb begin
    o_class    = DATA0;
    w_ones_nxt = '0;
    if (!i_din) begin
      // A zero after seven or more ones just ends the abort run.
      if (r_ones == STUFF_RUN)     o_class = STUFF;
      else if (r_ones == FLAG_RUN) o_class = FLAG;
      else                         o_class = DATA0;
    end else if (r_ones < STUFF_RUN) begin
      o_class    = DATA1;
      w_ones_nxt = r_ones + 3'd1;
    end else if (r_ones == STUFF_RUN) begin
      o_class    = SIX;
      w_ones_nxt = FLAG_RUN;
    end else begin
      o_class    = ABORT;
      w_ones_nxt = 3'd7;
    end
  end

  // Ones run advances on every strobe regardless of receiver state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_ones <= '0;
    else if (i_en) r_ones <= w_ones_nxt;
  end

endmodule

// File: rtl/hdlc_rx_ctrl.sv
// HDLC receive controller: de-stuffing, flag/abort framing, byte assembly and output FIFO.
module hdlc_rx_ctrl
  import hdlc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  hdlc_rx_ctrl_if.slave  bus
);

  localparam int unsigned      PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  bit_class_e       w_class;
  rx_state_e        r_state;
  logic [2:0]       r_bit_cnt;
  logic [6:0]       r_shift;
  logic [7:0]       r_hold;
  logic             r_hold_v;
  logic             r_pushed;   // some byte of the current frame is already queued
  logic             r_ovf;

  rx_entry_t        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;

  logic             w_active;
  logic             w_bit;
  logic [7:0]       w_byte;
  logic             w_push_req;
  logic             w_push_ok;
  logic             w_pop;
  logic             w_full;
  logic             w_overflow;
  rx_entry_t        w_entry;
  rx_entry_t        w_head;

  hdlc_bit_class u_bit_class (
    .clk     (clk),
    .rst     (rst),
    .i_en    (bus.en),
    .i_din   (bus.din),
    .o_class (w_class)
  );

  // Decide what, if anything, the current bit pushes into the FIFO.
  always_comb begin
    w_active   = bus.en && (r_state != HUNT);
    w_bit      = (w_class == DATA1);
    w_byte     = {w_bit, r_shift};
    w_push_req = 1'b0;
    w_entry    = '0;
    if (w_active) begin
      case (w_class)
        DATA0, DATA1: begin
          // Completing a byte releases the previous one, which is now known not to be last.
          if (r_bit_cnt == 3'd7 && r_hold_v) begin
            w_push_req = 1'b1;
            w_entry    = '{abort: 1'b0, sof: !r_pushed, eof: 1'b0, data: r_hold};
          end
        end
        FLAG: begin
          if (r_bit_cnt == 3'd6) begin
            // The six counted bits are the flag's own 0+11111.
            if (r_hold_v) begin
              w_push_req = 1'b1;
              w_entry    = '{abort: 1'b0, sof: !r_pushed, eof: 1'b1, data: r_hold};
            end
          end else if (r_pushed) begin
            w_push_req = 1'b1;
            w_entry    = '{abort: 1'b1, sof: 1'b0, eof: 1'b0, data: 8'h00};
          end
        end
        ABORT: begin
          if (r_pushed) begin
            w_push_req = 1'b1;
            w_entry    = '{abort: 1'b1, sof: 1'b0, eof: 1'b0, data: 8'h00};
          end
        end
        default: ;
      endcase
    end
    w_pop      = (r_count != '0) && bus.out_ready;
    w_full     = (r_count == FULL_CNT);
    w_overflow = w_push_req && w_full && !w_pop;
    w_push_ok  = w_push_req && !w_overflow;
  end

  // Framing FSM: hunt for a flag, then assemble bytes until a flag or abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= HUNT;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_hold    <= '0;
      r_hold_v  <= 1'b0;
      r_pushed  <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_overflow) begin
      // Frame is unrecoverable; drop it silently and resynchronise on the next flag.
      r_state   <= HUNT;
      r_hold_v  <= 1'b0;
      r_pushed  <= 1'b0;
      r_ovf     <= 1'b1;
    end else if (bus.en) begin
      case (r_state)
        HUNT: begin
          if (w_class == FLAG) begin
            r_state   <= OPEN;
            r_bit_cnt <= '0;
          end
        end
        OPEN, DATA: begin
          case (w_class)
            DATA0, DATA1: begin
              r_shift   <= w_byte[7:1];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_hold   <= w_byte;
                r_hold_v <= 1'b1;
                r_pushed <= r_pushed | r_hold_v;
                r_state  <= DATA;
              end
            end
            FLAG: begin
              r_state   <= OPEN;
              r_bit_cnt <= '0;
              r_hold_v  <= 1'b0;
              r_pushed  <= 1'b0;
            end
            ABORT: begin
              r_state  <= HUNT;
              r_hold_v <= 1'b0;
              r_pushed <= 1'b0;
            end
            default: ;
          endcase
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  // FIFO storage; reads are masked by out_valid so entries need no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= w_entry;
  end

  // FIFO pointers and occupancy; push and pop may coincide even when full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Show-ahead head of FIFO; all fields read as zero while empty.
  always_comb begin
    w_head        = r_mem[r_rptr];
    bus.out_valid = (r_count != '0);
    bus.out_data  = bus.out_valid ? w_head.data  : 8'h00;
    bus.out_sof   = bus.out_valid & w_head.sof;
    bus.out_eof   = bus.out_valid & w_head.eof;
    bus.out_abort = bus.out_valid & w_head.abort;
    bus.ovf       = r_ovf;
  end

endmodule

// File: tb/tb_hdlc_rx_ctrl.sv
// Directed bench for hdlc_rx_ctrl: table of frames plus hand-written corner sequences.
module tb_hdlc_rx_ctrl;
  import hdlc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hdlc_rx_ctrl_if bus ();

  hdlc_rx_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string            name;
    int               nbytes;
    logic [3:0][7:0]  bytes;
    bit               close_abort;
    int               nexp;
    logic [3:0][10:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [10:0] q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          tx_ones = 0;
  bit          gap_mode = 1'b0;

  // Capture every accepted entry; inputs change just after posedge, so negedge is stable.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready)
      q.push_back({bus.out_abort, bus.out_sof, bus.out_eof, bus.out_data});
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] ent(input logic a, input logic s, input logic e,
                                      input logic [7:0] d);
    return {a, s, e, d};
  endfunction

  function automatic logic [12:0] out_word();
    return {bus.ovf, bus.out_valid, bus.out_abort, bus.out_sof, bus.out_eof, bus.out_data};
  endfunction

  function automatic void add_vec(input string name, input int nb, input logic [7:0] b0,
                                  input logic [7:0] b1, input logic [7:0] b2, input bit ab,
                                  input int ne, input logic [10:0] e0, input logic [10:0] e1,
                                  input logic [10:0] e2);
    vec_t v;
    v.name        = name;
    v.nbytes      = nb;
    v.bytes       = {8'h00, b2, b1, b0};
    v.close_abort = ab;
    v.nexp        = ne;
    v.exp         = {11'h000, e2, e1, e0};
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_q(input string name, input int nexp, input logic [3:0][10:0] exp);
    logic [31:0] act;
    check({name, " count"}, q.size(), nexp);
    for (int i = 0; i < nexp; i++) begin
      act = (i < q.size()) ? {21'b0, q[i]} : 32'hFFFF_FFFF;
      check($sformatf("%s entry%0d", name, i), act, {21'b0, exp[i]});
    end
    q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    bus.en = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b);
    if (gap_mode) begin
      bus.en  = 1'b0;
      bus.din = ~b;
      tick();
    end
    bus.en  = 1'b1;
    bus.din = b;
    tick();
    bus.en  = 1'b0;
  endtask

  // Transmit-side zero insertion after five consecutive data ones.
  task automatic send_data_bit(input logic b);
    send_bit(b);
    if (b) begin
      tx_ones++;
      if (tx_ones == 5) begin
        send_bit(1'b0);
        tx_ones = 0;
      end
    end else begin
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_data_bit(v[i]);
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = FLAG_BYTE;
    for (int i = 0; i < 8; i++) send_bit(f[i]);
    tx_ones = 0;
  endtask

  task automatic send_abort();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    tx_ones = 0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.din       = 1'b0;
    bus.out_ready = 1'b1;

    add_vec("a5", 1, 8'hA5, 8'h00, 8'h00, 1'b0, 1,
            ent(0, 1, 1, 8'hA5), 11'h0, 11'h0);
    add_vec("12_34", 2, 8'h12, 8'h34, 8'h00, 1'b0, 2,
            ent(0, 1, 0, 8'h12), ent(0, 0, 1, 8'h34), 11'h0);
    add_vec("ff_stuff", 1, 8'hFF, 8'h00, 8'h00, 1'b0, 1,
            ent(0, 1, 1, 8'hFF), 11'h0, 11'h0);
    add_vec("abort", 2, 8'h11, 8'h22, 8'h00, 1'b1, 2,
            ent(0, 1, 0, 8'h11), ent(1, 0, 0, 8'h00), 11'h0);
    add_vec("three", 3, 8'h7E, 8'h00, 8'hC3, 1'b0, 3,
            ent(0, 1, 0, 8'h7E), ent(0, 0, 0, 8'h00), ent(0, 0, 1, 8'hC3));
    add_vec("abort_first", 1, 8'h5A, 8'h00, 8'h00, 1'b1, 0,
            11'h0, 11'h0, 11'h0);

    repeat (2) @(posedge clk);
    #2;
    check("reset outputs", {19'b0, out_word()}, 32'h0);
    rst = 1'b0;
    tick();
    check("post-reset idle", {19'b0, out_word()}, 32'h0);

    // Table of single frames, each opened by a flag and closed by a flag or abort.
    foreach (vecs[i]) begin
      send_flag();
      for (int j = 0; j < vecs[i].nbytes; j++) send_byte(vecs[i].bytes[j]);
      if (vecs[i].close_abort) send_abort();
      else                     send_flag();
      idle(6);
      check_q(vecs[i].name, vecs[i].nexp, vecs[i].exp);
    end

    // Shared flag between two frames, with en=0 gaps between bits.
    gap_mode = 1'b1;
    send_flag();
    send_byte(8'h0F);
    send_flag();
    send_byte(8'hF0);
    send_flag();
    gap_mode = 1'b0;
    idle(6);
    check_q("shared_flag", 2, {11'h0, 11'h0, ent(0, 1, 1, 8'hF0), ent(0, 1, 1, 8'h0F)});

    // Overflow with a stalled consumer.
    bus.out_ready = 1'b0;
    send_flag();
    for (int b = 1; b <= 5; b++) send_byte(8'(b));
    check("ovf before 5th push", {31'b0, bus.ovf}, 32'h0);
    send_byte(8'h06);
    check("ovf on 5th push", {31'b0, bus.ovf}, 32'h1);
    send_flag();
    idle(2);
    check("stalled head", {19'b0, out_word()}, {19'b0, 13'b1_1_0_1_0_00000001});
    bus.out_ready = 1'b1;
    idle(8);
    check_q("ovf_drain", 4, {ent(0, 0, 0, 8'h04), ent(0, 0, 0, 8'h03),
                             ent(0, 0, 0, 8'h02), ent(0, 1, 0, 8'h01)});
    send_flag();
    send_byte(8'h3C);
    send_flag();
    idle(6);
    check_q("after_ovf", 1, {11'h0, 11'h0, 11'h0, ent(0, 1, 1, 8'h3C)});
    check("ovf sticky", {31'b0, bus.ovf}, 32'h1);

    // Misaligned closing flag: three data bits only.
    send_flag();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_flag();
    idle(6);
    check_q("misaligned", 0, '0);
    check("misaligned idle", {31'b0, bus.out_valid}, 32'h0);

    // Asynchronous reset in the middle of a byte with a queued entry and ovf set.
    bus.out_ready = 1'b0;
    send_flag();
    send_byte(8'h12);
    send_byte(8'h34);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    check("pre-reset head", {19'b0, out_word()}, {19'b0, 13'b1_1_0_1_0_00010010});
    #1;
    rst = 1'b1;
    #1;
    check("async reset", {19'b0, out_word()}, 32'h0);
    tick();
    rst           = 1'b0;
    tx_ones       = 0;
    bus.out_ready = 1'b1;
    q.delete();
    // A byte with no preceding flag must be discarded while hunting.
    send_byte(8'h12);
    send_flag();
    send_byte(8'h99);
    send_flag();
    idle(6);
    check_q("hunt_after_reset", 1, {11'h0, 11'h0, 11'h0, ent(0, 1, 1, 8'h99)});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
